// File: rtl/mips_pkg.sv
// Shared fetch/decode constants and the {pc, instr} entry type carried through the prefetch queue.
package mips_pkg;

   localparam int INSTR_W = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0]        PC_RESET  = 32'h0000_0000;

   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } iq_entry_t;

endpackage

// File: rtl/instr_queue.sv
// Prefetch FIFO of {pc, instr} between fetch and decode; a pushed entry reaches id_* one cycle later (no bypass).
// if_ready falls only when full and ignores id_ready; flush empties the queue in one cycle and drops that cycle's push.
module instr_queue
   import mips_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               if_valid,
   input  logic [31:0]        if_pc,
   input  logic [INSTR_W-1:0] if_instr,
   output logic               if_ready,
   output logic               id_valid,
   output logic [31:0]        id_pc,
   output logic [INSTR_W-1:0] id_instr,
   input  logic               id_ready,
   output logic [PTR_W:0]     count
);

   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

   iq_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W:0]   r_cnt;

   logic      w_full;
   logic      w_empty;
   logic      w_push;
   logic      w_pop;
   iq_entry_t w_head;

   assign w_full  = (r_cnt == CNT_FULL);
   assign w_empty = (r_cnt == '0);

   // Full refuses a push even when a pop frees a slot this cycle, so if_ready stays a pure state decode.
   assign w_push = if_valid & ~w_full & ~flush;
   assign w_pop  = ~w_empty & id_ready & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_cnt    <= '0;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= '{pc: if_pc, instr: if_instr};
      end
   end

   assign w_head = r_mem[r_rd_ptr];

   assign if_ready = ~w_full;
   assign id_valid = ~w_empty;
   assign id_pc    = w_empty ? PC_RESET  : w_head.pc;
   assign id_instr = w_empty ? NOP_INSTR : w_head.instr;
   assign count    = r_cnt;

endmodule

// File: tb/tb_instr_queue.sv
// Randomized and directed checks of instr_queue against a queue-based model of the prefetch buffer.
module tb_instr_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_ready;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_ready;
   logic [2:0]  count;

   int checks   = 0;
   int failures = 0;

   logic [63:0] mq[$];

   instr_queue #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .if_valid (if_valid),
      .if_pc    (if_pc),
      .if_instr (if_instr),
      .if_ready (if_ready),
      .id_valid (id_valid),
      .id_pc    (id_pc),
      .id_instr (id_instr),
      .id_ready (id_ready),
      .count    (count)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, advance the model across the edge, and return #1 after it.
   task automatic tick(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
      bit do_push;
      bit do_pop;
      if_valid = v;
      if_pc    = pc;
      if_instr = ins;
      id_ready = rdy;
      flush    = fl;
      do_pop   = (mq.size() != 0) && rdy;
      do_push  = v && (mq.size() < DEPTH);
      @(posedge clk);
      if (fl) begin
         mq.delete();
      end else begin
         if (do_pop) void'(mq.pop_front());
         if (do_push) mq.push_back({pc, ins});
      end
      #1;
   endtask

   function automatic logic [31:0] exp_pc();
      return (mq.size() != 0) ? mq[0][63:32] : 32'h0;
   endfunction

   function automatic logic [31:0] exp_instr();
      return (mq.size() != 0) ? mq[0][31:0] : 32'h0;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; flush = 0; if_valid = 0; if_pc = 0; if_instr = 0; id_ready = 0;
      mq.delete();
      #2;
      checks++;
      if (count !== 3'd0 || if_ready !== 1'b1 || id_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_state count=%0d if_ready=%b id_valid=%b exp 0/1/0", count, if_ready, id_valid);
      end
      checks++;
      if (id_pc !== 32'h0 || id_instr !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs id_pc=%h id_instr=%h exp 0/0", id_pc, id_instr);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         tick(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0);
         checks++;
         if (count !== 3'(i + 1)) begin
            failures++;
            $display("FAIL fill_count step=%0d got=%0d exp=%0d", i, count, i + 1);
         end
      end
      checks++;
      if (if_ready !== 1'b0 || id_pc !== 32'h0) begin
         failures++;
         $display("FAIL fill_full if_ready=%b id_pc=%h exp 0/00000000", if_ready, id_pc);
      end
      tick(1'b1, 32'h10, $urandom, 1'b0, 1'b0);
      checks++;
      if (count !== 3'd4 || id_pc !== 32'h0 || id_instr !== exp_instr()) begin
         failures++;
         $display("FAIL fill_fifth count=%0d id_pc=%h exp 4/00000000", count, id_pc);
      end
   endtask

   task automatic test_drain();
      logic [31:0] seq [4];
      seq = '{32'h0, 32'h4, 32'h8, 32'hC};
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (id_valid !== 1'b1 || id_pc !== seq[i] || id_instr !== exp_instr()) begin
            failures++;
            $display("FAIL drain_head step=%0d id_valid=%b id_pc=%h exp 1/%h", i, id_valid, id_pc, seq[i]);
         end
         tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
      checks++;
      if (id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc !== 32'h0 || count !== 3'd0) begin
         failures++;
         $display("FAIL drain_empty id_valid=%b id_instr=%h id_pc=%h count=%0d exp 0/0/0/0",
                  id_valid, id_instr, id_pc, count);
      end
   endtask

   task automatic test_full_pop_only();
      for (int i = 0; i < DEPTH; i++) tick(1'b1, 32'h80 + 32'(i * 4), $urandom, 1'b0, 1'b0);
      tick(1'b1, 32'h90, $urandom, 1'b1, 1'b0);
      checks++;
      if (count !== 3'd3 || if_ready !== 1'b1 || id_pc !== 32'h84) begin
         failures++;
         $display("FAIL full_pop_only count=%0d if_ready=%b id_pc=%h exp 3/1/00000084", count, if_ready, id_pc);
      end
      tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      tick(1'b1, 32'h200, $urandom, 1'b0, 1'b0);
      tick(1'b1, 32'h204, $urandom, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick(1'b1, 32'h208 + 32'(i * 4), $urandom, 1'b1, 1'b0);
         checks++;
         if (count !== 3'd2 || id_pc !== 32'h204 + 32'(i * 4) || id_instr !== exp_instr()) begin
            failures++;
            $display("FAIL stream step=%0d count=%0d id_pc=%h exp 2/%h", i, count, id_pc,
                     32'h204 + 32'(i * 4));
         end
      end
      tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) tick(1'b1, 32'h30 + 32'(i * 4), $urandom, 1'b0, 1'b0);
      tick(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b1, 1'b1);
      checks++;
      if (count !== 3'd0 || id_valid !== 1'b0 || if_ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_empty count=%0d id_valid=%b if_ready=%b exp 0/0/1", count, id_valid, if_ready);
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
         checks++;
         if (id_valid !== 1'b0 || id_pc === 32'h40) begin
            failures++;
            $display("FAIL flush_dropped step=%0d id_valid=%b id_pc=%h exp 0/00000000", i, id_valid, id_pc);
         end
      end
      for (int i = 0; i < DEPTH; i++) tick(1'b1, 32'h50 + 32'(i * 4), $urandom, 1'b0, 1'b0);
      tick(1'b1, 32'h60, $urandom, 1'b1, 1'b1);
      checks++;
      if (count !== 3'd0 || if_ready !== 1'b1 || id_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_full count=%0d if_ready=%b id_valid=%b exp 0/1/0", count, if_ready, id_valid);
      end
   endtask

   task automatic test_latency();
      if_valid = 1'b1; if_pc = 32'h100; if_instr = 32'h1234_5678; id_ready = 1'b1; flush = 1'b0;
      #1;
      checks++;
      if (id_valid !== 1'b0) begin
         failures++;
         $display("FAIL latency_bypass id_valid=%b exp 0", id_valid);
      end
      tick(1'b1, 32'h100, 32'h1234_5678, 1'b1, 1'b0);
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== 32'h1234_5678 || count !== 3'd1) begin
         failures++;
         $display("FAIL latency_next id_valid=%b id_pc=%h id_instr=%h count=%0d exp 1/00000100/12345678/1",
                  id_valid, id_pc, id_instr, count);
      end
      tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
   endtask

   task automatic test_async_reset();
      tick(1'b1, 32'h300, $urandom, 1'b0, 1'b0);
      tick(1'b1, 32'h304, $urandom, 1'b0, 1'b0);
      if_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      mq.delete();
      #1;
      checks++;
      if (id_valid !== 1'b0 || count !== 3'd0 || if_ready !== 1'b1 || id_pc !== 32'h0) begin
         failures++;
         $display("FAIL async_reset id_valid=%b count=%0d if_ready=%b id_pc=%h exp 0/0/1/0",
                  id_valid, count, if_ready, id_pc);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic        v, rdy, fl;
      logic [31:0] pc;
      for (int i = 0; i < 400; i++) begin
         v   = 1'($urandom_range(0, 3) != 0);
         rdy = 1'($urandom_range(0, 2) != 0);
         fl  = 1'($urandom_range(0, 19) == 0);
         pc  = {$urandom_range(0, 32'h3FFF), 2'b00};
         tick(v, pc, $urandom, rdy, fl);
         checks++;
         if (count !== 3'(mq.size()) || if_ready !== (mq.size() != DEPTH) ||
             id_valid !== (mq.size() != 0) || id_pc !== exp_pc() || id_instr !== exp_instr()) begin
            failures++;
            $display("FAIL random step=%0d count=%0d/%0d if_ready=%b id_valid=%b id_pc=%h/%h id_instr=%h/%h",
                     i, count, mq.size(), if_ready, id_valid, id_pc, exp_pc(), id_instr, exp_instr());
         end
      end
   endtask

   initial begin
      test_reset();
      @(posedge clk); #1;
      test_fill();
      test_drain();
      test_full_pop_only();
      test_back_to_back();
      test_flush();
      test_latency();
      test_async_reset();
      @(posedge clk); #1;
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
